// File: rtl/accum_arb_pkg.sv
// Shared types and defaults for the round-robin accumulator arbiter.
package accum_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int DATA_W_DEF    = 8;
  localparam int GROUP_LEN_DEF = 4;

  // (a + b) mod n for small non-negative operands (b < n).
  function automatic int mod_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotate via a doubled vector so bit 0 of rot is requester ptr, then take the lowest set bit.
  always_comb begin
    dbl = {req, req};
    rot = NUM_REQ'(dbl >> ptr);
    any = |req;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = ID_W'(mod_add(int'(ptr), k, NUM_REQ));
    end
  end

endmodule

// File: rtl/accum_rr_arbiter.sv
// Round-robin arbiter that locks one requester onto the accumulator for a full group.
module accum_rr_arbiter
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int GROUP_LEN = GROUP_LEN_DEF,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      acc_valid,
  output logic [DATA_W-1:0]         acc_data,
  input  logic                      acc_ready,
  output logic                      acc_last,
  output logic [ID_W-1:0]           acc_id,
  output logic                      grant_vld,
  output logic [ID_W-1:0]           grant_id
);

  localparam int              CNT_W    = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_LEN - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Zero-latency pass-through of the granted requester; everything is quiet outside LOCK.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    acc_valid = 1'b0;
    acc_data  = '0;
    acc_last  = 1'b0;
    acc_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    if (state_q == ST_LOCK) begin
      acc_valid = sel_valid;
      acc_data  = sel_data;
      acc_last  = (beat_cnt_q == LAST_CNT) & sel_valid;
      acc_id    = grant_id_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_id_q == ID_W'(i)) & acc_ready;
      end
    end
  end

  assign xfer      = acc_valid & acc_ready;
  assign grant_vld = (state_q == ST_LOCK);
  assign grant_id  = grant_id_q;

  // Next-state: arbitrate in IDLE, count beats in LOCK, release and advance pointer on the last beat.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (xfer) begin
          if (acc_last) begin
            beat_cnt_d = '0;
            rr_ptr_d   = ID_W'(mod_add(int'(grant_id_q), 1, NUM_REQ));
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any group in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_accum_rr_arbiter.sv
// Self-checking bench: directed table, corner-case sequences, random traffic vs a group-level model.
module tb_accum_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GL = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            acc_valid;
  logic [DW-1:0]   acc_data;
  logic            acc_ready;
  logic            acc_last;
  logic [IW-1:0]   acc_id;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;

  accum_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GROUP_LEN(GL), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_ready (acc_ready),
    .acc_last  (acc_last),
    .acc_id    (acc_id),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Group-level model: owner (-1 = nobody), beats done in the group, next starting point.
  int m_own  = -1;
  int m_done = 0;
  int m_ptr  = 0;

  // Observed downstream groups.
  int grp_ids[$];
  int grp_sums[$];
  int grp_lens[$];
  int run_sum = 0;
  int run_len = 0;

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] d;
    logic       rdy;
    logic       gv;
    logic [1:0] gid;
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic [3:0] rr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [DW-1:0] base, input logic rdy);
    req_valid = v;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + DW'(i);
    acc_ready = rdy;
  endtask

  task automatic row(input logic [3:0] v, input logic [7:0] d, input logic rdy, input logic gv,
                     input logic [1:0] gid, input logic av, input logic [7:0] ad, input logic al,
                     input logic [3:0] rr);
    tbl.push_back({v, d, rdy, gv, gid, av, ad, al, rr});
  endtask

  task automatic model_check();
    logic          e_av;
    logic [DW-1:0] e_ad;
    logic          e_al;
    logic [N-1:0]  e_rr;
    e_av = 1'b0; e_ad = '0; e_al = 1'b0; e_rr = '0;
    if (m_own >= 0) begin
      e_av = req_valid[m_own];
      e_ad = req_data[m_own*DW +: DW];
      e_al = e_av && (m_done == GL - 1);
      if (acc_ready) e_rr[m_own] = 1'b1;
      chk("m_grant_id", grant_id, m_own);
    end
    chk("m_grant_vld", grant_vld, (m_own >= 0));
    chk("m_acc_valid", acc_valid, e_av);
    chk("m_acc_data",  acc_data,  e_ad);
    chk("m_acc_last",  acc_last,  e_al);
    chk("m_acc_id",    acc_id,    (m_own >= 0) ? m_own : 0);
    chk("m_req_ready", req_ready, e_rr);
  endtask

  task automatic model_step();
    bit found;
    found = 0;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found  = 1;
          m_own  = (m_ptr + k) % N;
          m_done = 0;
        end
      end
    end else if (req_valid[m_own] && acc_ready) begin
      m_done++;
      if (m_done == GL) begin
        m_ptr  = (m_own + 1) % N;
        m_own  = -1;
        m_done = 0;
      end
    end
  endtask

  task automatic log_beat();
    if (acc_valid && acc_ready) begin
      run_sum += int'(acc_data);
      run_len++;
      if (acc_last) begin
        grp_ids.push_back(int'(acc_id));
        grp_sums.push_back(run_sum);
        grp_lens.push_back(run_len);
        run_sum = 0;
        run_len = 0;
      end
    end
  endtask

  // One clock: check against the model mid-cycle, advance the model, land just after the edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    log_beat();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_outputs", {grant_vld, acc_valid, acc_last, req_ready, acc_id, grant_id, acc_data}, 0);
    m_own = -1; m_done = 0; m_ptr = 0;
    run_sum = 0; run_len = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    set_in('0, '0, 1'b0);
    #1;
    do_reset();

    // Single requester 0, then backpressured requester 2, then wrap-and-skip to requester 1.
    row(4'b0001, 8'd10, 1, 0, 0, 0, 8'd0,  0, 4'b0000);
    row(4'b0001, 8'd10, 1, 1, 0, 1, 8'd10, 0, 4'b0001);
    row(4'b0001, 8'd20, 1, 1, 0, 1, 8'd20, 0, 4'b0001);
    row(4'b0001, 8'd30, 1, 1, 0, 1, 8'd30, 0, 4'b0001);
    row(4'b0001, 8'd40, 1, 1, 0, 1, 8'd40, 1, 4'b0001);
    row(4'b0000, 8'd0,  1, 0, 0, 0, 8'd0,  0, 4'b0000);
    row(4'b0100, 8'd50, 1, 0, 0, 0, 8'd0,  0, 4'b0000);
    row(4'b0100, 8'd50, 1, 1, 2, 1, 8'd52, 0, 4'b0100);
    row(4'b0100, 8'd60, 0, 1, 2, 1, 8'd62, 0, 4'b0000);
    row(4'b0100, 8'd60, 1, 1, 2, 1, 8'd62, 0, 4'b0100);
    row(4'b0100, 8'd70, 0, 1, 2, 1, 8'd72, 0, 4'b0000);
    row(4'b0100, 8'd70, 1, 1, 2, 1, 8'd72, 0, 4'b0100);
    row(4'b0100, 8'd80, 0, 1, 2, 1, 8'd82, 1, 4'b0000);
    row(4'b0100, 8'd80, 0, 1, 2, 1, 8'd82, 1, 4'b0000);
    row(4'b0100, 8'd80, 1, 1, 2, 1, 8'd82, 1, 4'b0100);
    row(4'b0010, 8'd90, 1, 0, 0, 0, 8'd0,  0, 4'b0000);
    row(4'b0010, 8'd90, 1, 1, 1, 1, 8'd91, 0, 4'b0010);
    row(4'b0010, 8'd91, 1, 1, 1, 1, 8'd92, 0, 4'b0010);
    row(4'b0010, 8'd92, 1, 1, 1, 1, 8'd93, 0, 4'b0010);
    row(4'b0010, 8'd93, 1, 1, 1, 1, 8'd94, 1, 4'b0010);
    row(4'b1111, 8'd0,  1, 0, 0, 0, 8'd0,  0, 4'b0000);
    row(4'b1111, 8'd0,  1, 1, 2, 1, 8'd2,  0, 4'b0100);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].v, tbl[i].d, tbl[i].rdy);
      #3;
      chk($sformatf("tbl%0d_gv", i), grant_vld, tbl[i].gv);
      chk($sformatf("tbl%0d_av", i), acc_valid, tbl[i].av);
      chk($sformatf("tbl%0d_ad", i), acc_data,  tbl[i].ad);
      chk($sformatf("tbl%0d_al", i), acc_last,  tbl[i].al);
      chk($sformatf("tbl%0d_rr", i), req_ready, tbl[i].rr);
      chk($sformatf("tbl%0d_id", i), acc_id,    tbl[i].gv ? tbl[i].gid : 2'd0);
      if (tbl[i].gv) chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
      cycle();
    end
    chk("tbl_groups", grp_ids.size(), 3);
    if (grp_ids.size() >= 3) begin
      chk("single_sum", grp_sums[0], 100);
      chk("single_id",  grp_ids[0], 0);
      chk("bp_id",      grp_ids[1], 2);
      chk("bp_len",     grp_lens[1], GL);
      chk("wrap_id",    grp_ids[2], 1);
    end

    // All four requesting continuously from a fresh reset.
    do_reset();
    grp_ids.delete(); grp_sums.delete(); grp_lens.delete();
    for (int c = 0; c < 25; c++) begin
      set_in(4'b1111, DW'(c * 7), 1'b1);
      cycle();
    end
    chk("all_groups", grp_ids.size(), 5);
    if (grp_ids.size() == 5) begin
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("all_order%0d", g), grp_ids[g], g % N);
        chk($sformatf("all_len%0d", g),   grp_lens[g], GL);
      end
    end

    // Granted source stalls mid-group while requester 3 waits.
    grp_ids.delete(); grp_sums.delete(); grp_lens.delete();
    set_in(4'b1010, 8'd100, 1'b1);
    cycle();
    cycle();
    cycle();
    for (int c = 0; c < 3; c++) begin
      set_in(4'b1000, 8'd120, 1'b1);
      #3;
      chk("stall_hold_id", {grant_vld, grant_id}, {1'b1, 2'd1});
      chk("stall_rr3", req_ready[3], 1'b0);
      cycle();
    end
    set_in(4'b1010, 8'd130, 1'b1);
    cycle();
    cycle();
    cycle();
    #3;
    chk("stall_next_grant", {grant_vld, grant_id}, {1'b1, 2'd3});
    chk("stall_groups", grp_ids.size(), 1);
    if (grp_ids.size() == 1) chk("stall_len", grp_lens[0], GL);

    // Reset in the middle of requester 3's group.
    set_in(4'b1111, 8'd140, 1'b1);
    cycle();
    cycle();
    do_reset();
    cycle();
    #3;
    chk("rst_regrant", {grant_vld, grant_id, acc_last}, {1'b1, 2'd0, 1'b0});

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      set_in(N'($urandom_range(0, 15)), DW'($urandom), ($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
